uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART_TX serializer between NUM_REQ byte producers. Each requester offers a byte with a valid/ready handshake; the arbiter accepts one byte at a time, launches it into UART_TX with a single-cycle i_TX_DV strobe, waits for the serializer's done pulse, then returns a per-requester completion pulse. It sits between the command/debug sources and the UART_TX instance. The serial line mux (TX_Active ? TX_Serial : 1) stays outside this block.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 38 +++
 rtl/uart_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// Timeout watchdog is built only with UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int TIMEOUT_CLKS_DEF = 2400;

  function automatic int grant_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer handshake bundle for uart_tx_arbiter.
// slave is the arbiter view, master the producer/serializer view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  localparam int GW = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Req_Done;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic [GW-1:0]        o_Grant_ID;
  logic                 o_Busy;
  logic                 o_Timeout;

  modport slave (
    input  i_Req_Valid, i_Req_Byte,
    input  i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_Req_Done,
    output o_TX_DV, o_TX_Byte,
    output o_Grant_ID, o_Busy, o_Timeout
  );

  modport master (
    output i_Req_Valid, i_Req_Byte,
    output i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_Req_Done,
    input  o_TX_DV, o_TX_Byte,
    input  o_Grant_ID, o_Busy, o_Timeout
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above ptr, wrapping to index 0.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      id
);

  logic found;

  // upper pass from ptr, then wrapped pass below ptr
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i >= int'(ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        id       = GW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i < int'(ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        id       = GW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART_TX between NUM_REQ producers.
// Optional watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int GW = grant_w(NUM_REQ);

  arb_state_t         state;
  logic [GW-1:0]      ptr;
  logic [GW-1:0]      gid;
  logic               dv;
  logic [7:0]         tbyte;
  logic [NUM_REQ-1:0] rdone;
  logic               busy;

  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0]      pick_id;
  logic [GW-1:0]      ptr_nxt;
  logic [7:0]         pick_byte;
  logic [NUM_REQ-1:0] done_vec;
  logic [NUM_REQ-1:0] ready;
  logic               hs;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req   (bus.i_Req_Valid),
    .ptr   (ptr),
    .grant (grant),
    .id    (pick_id)
  );

  always_comb begin
    pick_byte = '0;
    done_vec  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i])
        pick_byte = bus.i_Req_Byte[8*i +: 8];
      done_vec[i] = (gid == GW'(i));
    end
  end

  assign ptr_nxt = (pick_id == GW'(NUM_REQ-1))
                 ? '0 : pick_id + GW'(1);

  // a frame left running across reset blocks new grants
  assign ready = (state == IDLE && !bus.i_TX_Active)
               ? grant : '0;
  assign hs    = |(ready & bus.i_Req_Valid);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CLKS);
  logic [CW-1:0] cnt;
  logic          tmo;
`else
  wire unused_timeout = |TIMEOUT_CLKS;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= IDLE;
      ptr   <= '0;
      gid   <= '0;
      dv    <= 1'b0;
      tbyte <= '0;
      rdone <= '0;
      busy  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt   <= '0;
      tmo   <= 1'b0;
`endif
    end else begin
      dv    <= 1'b0;
      rdone <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (hs) begin
            tbyte <= pick_byte;
            gid   <= pick_id;
            ptr   <= ptr_nxt;
            dv    <= 1'b1;
            busy  <= 1'b1;
            state <= LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        LAUNCH: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.i_TX_Done) begin
            rdone <= done_vec;
            state <= GAP;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CLKS-2)) begin
            tmo   <= 1'b1;
            state <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Req_Ready = ready;
  assign bus.o_Req_Done  = rdone;
  assign bus.o_TX_DV     = dv;
  assign bus.o_TX_Byte   = tbyte;
  assign bus.o_Grant_ID  = gid;
  assign bus.o_Busy      = busy;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.o_Timeout   = tmo;
`else
  assign bus.o_Timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-exact
// serializer model; watchdog test depends on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .TIMEOUT_CLKS (50)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int r, input logic [7:0] b);
    bus.i_Req_Byte[8*r +: 8] = b;
  endtask

  task automatic xfer(input int w, input logic [7:0] b,
                      input bit keep, input int len);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    #1;
    chk("ready_idle", bus.o_Req_Ready, oh);
    chk("busy_idle", bus.o_Busy, 0);
    tick();
    chk("dv_launch", bus.o_TX_DV, 1);
    chk("byte_launch", bus.o_TX_Byte, b);
    chk("grant_id", bus.o_Grant_ID, w);
    chk("ready_launch", bus.o_Req_Ready, 0);
    chk("busy_launch", bus.o_Busy, 1);
    if (!keep) bus.i_Req_Valid[w] = 1'b0;
    bus.i_TX_Active = 1'b1;
    tick();
    chk("dv_single", bus.o_TX_DV, 0);
    repeat (len) tick();
    chk("dv_wait", bus.o_TX_DV, 0);
    chk("done_early", bus.o_Req_Done, 0);
    bus.i_TX_Done   = 1'b1;
    bus.i_TX_Active = 1'b0;
    tick();
    bus.i_TX_Done = 1'b0;
    chk("req_done", bus.o_Req_Done, oh);
    chk("byte_held", bus.o_TX_Byte, b);
    chk("ready_gap", bus.o_Req_Ready, 0);
    tick();
    chk("done_clear", bus.o_Req_Done, 0);
    chk("busy_clear", bus.o_Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_Req_Valid = '0;
    bus.i_Req_Byte  = '0;
    bus.i_TX_Active = 1'b0;
    bus.i_TX_Done   = 1'b0;
    tick();
    tick();
    chk("rst_dv", bus.o_TX_DV, 0);
    chk("rst_byte", bus.o_TX_Byte, 0);
    chk("rst_ready", bus.o_Req_Ready, 0);
    chk("rst_done", bus.o_Req_Done, 0);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_tmo", bus.o_Timeout, 0);
    chk("rst_grant", bus.o_Grant_ID, 0);
    rst = 1'b0;

    // single request from requester 2
    set_byte(2, 8'h3F);
    bus.i_Req_Valid = 4'b0100;
    xfer(2, 8'h3F, 1'b0, 3);

    // all four at once from P=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_byte(0, 8'h11);
    set_byte(1, 8'h22);
    set_byte(2, 8'h33);
    set_byte(3, 8'h44);
    bus.i_Req_Valid = 4'b1111;
    xfer(0, 8'h11, 1'b0, 2);
    xfer(1, 8'h22, 1'b0, 2);
    xfer(2, 8'h33, 1'b0, 2);
    xfer(3, 8'h44, 1'b0, 2);

    // fairness: 0 held, 3 once -> 0,3,0
    set_byte(0, 8'h55);
    set_byte(3, 8'h66);
    bus.i_Req_Valid = 4'b0001;
    xfer(0, 8'h55, 1'b1, 2);
    bus.i_Req_Valid[3] = 1'b1;
    xfer(3, 8'h66, 1'b0, 2);
    xfer(0, 8'h55, 1'b0, 2);

    // reset mid-frame, P=1 so requester 1 wins
    set_byte(1, 8'h77);
    bus.i_Req_Valid = 4'b0010;
    #1;
    chk("mr_ready", bus.o_Req_Ready, 4'b0010);
    tick();
    chk("mr_grant", bus.o_Grant_ID, 1);
    bus.i_Req_Valid = '0;
    bus.i_TX_Active = 1'b1;
    tick();
    tick();
    chk("mr_busy", bus.o_Busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_dv", bus.o_TX_DV, 0);
    chk("mr_byte", bus.o_TX_Byte, 0);
    chk("mr_done", bus.o_Req_Done, 0);
    chk("mr_busy0", bus.o_Busy, 0);
    chk("mr_grant0", bus.o_Grant_ID, 0);
    chk("mr_tmo", bus.o_Timeout, 0);
    set_byte(2, 8'hA5);
    bus.i_Req_Valid = 4'b0100;
    #1;
    chk("mr_block", bus.o_Req_Ready, 0);
    tick();
    chk("mr_block2", bus.o_Req_Ready, 0);
    chk("mr_nodv", bus.o_TX_DV, 0);
    bus.i_Req_Valid = '0;
    bus.i_TX_Done   = 1'b1;
    bus.i_TX_Active = 1'b0;
    tick();
    bus.i_TX_Done = 1'b0;
    chk("mr_ignore", bus.o_Req_Done, 0);
    chk("mr_idle", bus.o_Busy, 0);
    bus.i_Req_Valid = 4'b0100;
    xfer(2, 8'hA5, 1'b0, 4);

    // stuck serializer, P=3 so requester 0 wins
    set_byte(0, 8'h5A);
    bus.i_Req_Valid = 4'b0001;
    #1;
    chk("st_ready", bus.o_Req_Ready, 4'b0001);
    tick();
    chk("st_dv", bus.o_TX_DV, 1);
    bus.i_Req_Valid = '0;
    bus.i_TX_Active = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (49) tick();
    chk("to_early", bus.o_Timeout, 0);
    chk("to_busy", bus.o_Busy, 1);
    tick();
    chk("to_pulse", bus.o_Timeout, 1);
    chk("to_nodone", bus.o_Req_Done, 0);
    tick();
    chk("to_clear", bus.o_Timeout, 0);
    chk("to_idle", bus.o_Busy, 0);
    bus.i_TX_Active = 1'b0;
    bus.i_Req_Valid = 4'b0010;
    xfer(1, 8'h77, 1'b0, 2);
`else
    bus.i_Req_Valid = 4'b0010;
    repeat (60) tick();
    chk("st_busy", bus.o_Busy, 1);
    chk("st_tmo", bus.o_Timeout, 0);
    chk("st_nodone", bus.o_Req_Done, 0);
    chk("st_nodv", bus.o_TX_DV, 0);
    chk("st_noready", bus.o_Req_Ready, 0);
    rst = 1'b1;
    bus.i_Req_Valid = '0;
    bus.i_TX_Active = 1'b0;
    tick();
    rst = 1'b0;
    chk("st_recover", bus.o_Busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
